// File: rtl/tiny_riscv_pkg.sv
// Shared encodings for the tiny_riscv memory arbiter: FSM states and grant IDs.
// Kept as plain localparam constants so legacy blocks can compare against them directly.
package tiny_riscv_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_D  = 1'b1;

    // The port that did not win last time; used to break ties.
    function automatic logic other_grant(input logic grant);
        return (grant == GRANT_IF) ? GRANT_D : GRANT_IF;
    endfunction

endpackage

// File: rtl/tiny_riscv_rr_arbiter2.sv
// Two-way combinational round-robin pick between the fetch and load/store ports.
// A lone requester always wins; on a tie the port that was not granted last wins.
module tiny_riscv_rr_arbiter2
    import tiny_riscv_pkg::*;
(
    input  logic req_if,
    input  logic req_d,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the block leaves it unassigned (no latch).
        grant_valid = req_if | req_d;
        grant       = GRANT_IF;
        if (req_if && req_d) begin
            grant = other_grant(last_grant);
        end else if (req_d) begin
            grant = GRANT_D;
        end
    end

endmodule

// File: rtl/tiny_riscv_mem_arbiter.sv
// Shares one single-port memory between the fetch (IF) and load/store (D) ports of the core.
// One transaction at a time: IDLE -> CMD -> WAIT -> RESP, round-robin between the two ports.
module tiny_riscv_mem_arbiter
    import tiny_riscv_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_IF_Req,
    input  logic [ADDR_WIDTH-1:0]   i_IF_Addr,
    output logic                    o_IF_Ack,
    output logic [DATA_WIDTH-1:0]   o_IF_RData,
    input  logic                    i_D_Req,
    input  logic [ADDR_WIDTH-1:0]   i_D_Addr,
    input  logic                    i_D_We,
    input  logic [DATA_WIDTH/8-1:0] i_D_WStrb,
    input  logic [DATA_WIDTH-1:0]   i_D_WData,
    output logic                    o_D_Ack,
    output logic [DATA_WIDTH-1:0]   o_D_RData,
    output logic                    o_Mem_En,
    output logic [ADDR_WIDTH-1:0]   o_Mem_Addr,
    output logic [DATA_WIDTH/8-1:0] o_Mem_WStrb,
    output logic [DATA_WIDTH-1:0]   o_Mem_WData,
    input  logic [DATA_WIDTH-1:0]   i_Mem_RData,
    output logic                    o_Busy
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(MEM_LATENCY - 1);

    logic [1:0]            state;
    logic                  last_grant;
    logic                  grant;
    logic [CNT_WIDTH-1:0]  wait_cnt;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [STRB_WIDTH-1:0] mem_wstrb;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic pick_valid;
    logic pick;

    tiny_riscv_rr_arbiter2 u_rr_arbiter2 (
        .req_if      (i_IF_Req),
        .req_d       (i_D_Req),
        .last_grant  (last_grant),
        .grant_valid (pick_valid),
        .grant       (pick)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_IF;
            grant      <= GRANT_IF;
            wait_cnt   <= '0;
            mem_addr   <= '0;
            mem_wstrb  <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant      <= pick;
                        last_grant <= pick;
                        if (pick == GRANT_D) begin
                            mem_addr  <= i_D_Addr;
                            mem_wstrb <= i_D_We ? i_D_WStrb : '0;
                            mem_wdata <= i_D_WData;
                        end else begin
                            mem_addr  <= i_IF_Addr;
                            mem_wstrb <= '0;
                            mem_wdata <= '0;
                        end
                        state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    wait_cnt <= CNT_LOAD;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Read data is valid in the cycle where the counter has run down to zero.
                    if (wait_cnt == '0) begin
                        if (grant == GRANT_D) begin
                            d_rdata <= i_Mem_RData;
                        end else begin
                            if_rdata <= i_Mem_RData;
                        end
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_WIDTH'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Mem_En    = (state == ST_CMD);
    assign o_Mem_Addr  = mem_addr;
    assign o_Mem_WStrb = mem_wstrb;
    assign o_Mem_WData = mem_wdata;
    assign o_IF_Ack    = (state == ST_RESP) && (grant == GRANT_IF);
    assign o_D_Ack     = (state == ST_RESP) && (grant == GRANT_D);
    assign o_IF_RData  = if_rdata;
    assign o_D_RData   = d_rdata;
    assign o_Busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_tiny_riscv_mem_arbiter.sv
// Directed bench for tiny_riscv_mem_arbiter: one instance with MEM_LATENCY=1 and one with
// MEM_LATENCY=3 share stimulus, each backed by its own behavioural memory.
module tb_tiny_riscv_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_we;
    logic [3:0]  d_wstrb;
    logic [31:0] d_wdata;

    logic        if_ack1, d_ack1, mem_en1, busy1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic [3:0]  mem_wstrb1;
    logic        if_ack3, d_ack3, mem_en3, busy3;
    logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic [3:0]  mem_wstrb3;

    int n_cmp;
    int n_bad;

    tiny_riscv_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) u_dut1 (
        .i_Clk(clk), .i_Rst(rst),
        .i_IF_Req(if_req), .i_IF_Addr(if_addr), .o_IF_Ack(if_ack1), .o_IF_RData(if_rdata1),
        .i_D_Req(d_req), .i_D_Addr(d_addr), .i_D_We(d_we), .i_D_WStrb(d_wstrb), .i_D_WData(d_wdata),
        .o_D_Ack(d_ack1), .o_D_RData(d_rdata1),
        .o_Mem_En(mem_en1), .o_Mem_Addr(mem_addr1), .o_Mem_WStrb(mem_wstrb1), .o_Mem_WData(mem_wdata1),
        .i_Mem_RData(mem_rdata1), .o_Busy(busy1)
    );

    tiny_riscv_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) u_dut3 (
        .i_Clk(clk), .i_Rst(rst),
        .i_IF_Req(if_req), .i_IF_Addr(if_addr), .o_IF_Ack(if_ack3), .o_IF_RData(if_rdata3),
        .i_D_Req(d_req), .i_D_Addr(d_addr), .i_D_We(d_we), .i_D_WStrb(d_wstrb), .i_D_WData(d_wdata),
        .o_D_Ack(d_ack3), .o_D_RData(d_rdata3),
        .o_Mem_En(mem_en3), .o_Mem_Addr(mem_addr3), .o_Mem_WStrb(mem_wstrb3), .o_Mem_WData(mem_wdata3),
        .i_Mem_RData(mem_rdata3), .o_Busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memories: word 0x10 holds 0x13, every other word index i holds 0xA500_iiii.
    logic [31:0] mem1 [0:63];
    bit          wv1  [0:63];
    logic [31:0] mem3 [0:63];
    bit          wv3  [0:63];
    logic [31:0] pipe3_s0, pipe3_s1;

    function automatic logic [31:0] init_word(input logic [5:0] idx);
        if (idx == 6'd4) return 32'h0000_0013;
        return 32'hA500_0000 | {16'h0, 2'b00, idx, 2'b00, idx};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] cur1(input logic [5:0] idx);
        return wv1[idx] ? mem1[idx] : init_word(idx);
    endfunction

    function automatic logic [31:0] cur3(input logic [5:0] idx);
        return wv3[idx] ? mem3[idx] : init_word(idx);
    endfunction

    always @(posedge clk) begin
        mem_rdata1 <= 32'hBAD0_BAD0;
        if (mem_en1) begin
            mem_rdata1 <= cur1(mem_addr1[7:2]);
            if (mem_wstrb1 != 4'b0000) begin
                mem1[mem_addr1[7:2]] <= merge(cur1(mem_addr1[7:2]), mem_wdata1, mem_wstrb1);
                wv1[mem_addr1[7:2]]  <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        pipe3_s0   <= mem_en3 ? cur3(mem_addr3[7:2]) : 32'hBAD0_BAD0;
        pipe3_s1   <= pipe3_s0;
        mem_rdata3 <= pipe3_s1;
        if (mem_en3 && mem_wstrb3 != 4'b0000) begin
            mem3[mem_addr3[7:2]] <= merge(cur3(mem_addr3[7:2]), mem_wdata3, mem_wstrb3);
            wv3[mem_addr3[7:2]]  <= 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req  = 1'b0;
        if_addr = 32'h0;
        d_req   = 1'b0;
        d_addr  = 32'h0;
        d_we    = 1'b0;
        d_wstrb = 4'h0;
        d_wdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({if_ack1, d_ack1, mem_en1, busy1, if_rdata1, d_rdata1, mem_addr1, mem_wstrb1, mem_wdata1} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs_lat1: got %h want 0",
                     {if_ack1, d_ack1, mem_en1, busy1, if_rdata1, d_rdata1, mem_addr1, mem_wstrb1, mem_wdata1});
        end
        n_cmp++;
        if ({if_ack3, d_ack3, mem_en3, busy3, if_rdata3, d_rdata3, mem_addr3, mem_wstrb3, mem_wdata3} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs_lat3: got %h want 0",
                     {if_ack3, d_ack3, mem_en3, busy3, if_rdata3, d_rdata3, mem_addr3, mem_wstrb3, mem_wdata3});
        end
        step();
        rst = 1'b0;
        step();
        n_cmp++;
        if ({busy1, mem_en1, busy3, mem_en3} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_release_idle: got %b want 0000", {busy1, mem_en1, busy3, mem_en3});
        end
    endtask

    task automatic test_single_if_read();
        do_reset();
        if_addr = 32'h10;
        if_req  = 1'b1;
        n_cmp++;
        if (busy1 !== 1'b0) begin n_bad++; $display("FAIL if_read_c0_busy: got %b want 0", busy1); end
        step();
        n_cmp++;
        if ({mem_en1, busy1, mem_addr1, mem_wstrb1} !== {1'b1, 1'b1, 32'h10, 4'h0}) begin
            n_bad++;
            $display("FAIL if_read_c1_cmd: got en=%b busy=%b addr=%h strb=%h want en=1 busy=1 addr=10 strb=0",
                     mem_en1, busy1, mem_addr1, mem_wstrb1);
        end
        step();
        n_cmp++;
        if ({mem_en1, if_ack1} !== 2'b00) begin n_bad++; $display("FAIL if_read_c2_quiet: got %b want 00", {mem_en1, if_ack1}); end
        step();
        n_cmp++;
        if ({if_ack1, d_ack1, if_rdata1} !== {1'b1, 1'b0, 32'h0000_0013}) begin
            n_bad++;
            $display("FAIL if_read_c3_ack: got ifack=%b dack=%b rdata=%h want 1 0 00000013", if_ack1, d_ack1, if_rdata1);
        end
        if_req = 1'b0;
        step();
        n_cmp++;
        if ({if_ack1, busy1, if_rdata1} !== {1'b0, 1'b0, 32'h0000_0013}) begin
            n_bad++;
            $display("FAIL if_read_c4_hold: got ack=%b busy=%b rdata=%h want 0 0 00000013", if_ack1, busy1, if_rdata1);
        end
    endtask

    task automatic test_tie_alternate();
        logic [1:0]  exp_acks;
        logic        exp_en;
        do_reset();
        if_addr = 32'h24;
        d_addr  = 32'h20;
        d_we    = 1'b0;
        if_req  = 1'b1;
        d_req   = 1'b1;
        for (int c = 0; c < 16; c++) begin
            exp_acks = 2'b00;
            if (c % 4 == 3) exp_acks = ((c / 4) % 2 == 0) ? 2'b01 : 2'b10;
            exp_en = (c % 4 == 1);
            n_cmp++;
            if ({if_ack1, d_ack1, mem_en1} !== {exp_acks, exp_en}) begin
                n_bad++;
                $display("FAIL tie_cycle%0d: got ifack,dack,en=%b want %b", c, {if_ack1, d_ack1, mem_en1}, {exp_acks, exp_en});
            end
            if (exp_acks == 2'b01) begin
                n_cmp++;
                if (d_rdata1 !== 32'hA500_0808) begin
                    n_bad++;
                    $display("FAIL tie_d_rdata_c%0d: got %h want a5000808", c, d_rdata1);
                end
            end
            if (exp_acks == 2'b10) begin
                n_cmp++;
                if (if_rdata1 !== 32'hA500_0909) begin
                    n_bad++;
                    $display("FAIL tie_if_rdata_c%0d: got %h want a5000909", c, if_rdata1);
                end
            end
            if (c == 15) begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_store();
        do_reset();
        d_addr  = 32'h40;
        d_we    = 1'b1;
        d_wstrb = 4'b0011;
        d_wdata = 32'hDEAD_BEEF;
        d_req   = 1'b1;
        step();
        n_cmp++;
        if ({mem_en1, mem_addr1, mem_wstrb1, mem_wdata1} !== {1'b1, 32'h40, 4'b0011, 32'hDEAD_BEEF}) begin
            n_bad++;
            $display("FAIL store_c1_cmd: got en=%b addr=%h strb=%b wdata=%h want 1 40 0011 deadbeef",
                     mem_en1, mem_addr1, mem_wstrb1, mem_wdata1);
        end
        step();
        step();
        n_cmp++;
        if ({d_ack1, if_ack1} !== 2'b10) begin n_bad++; $display("FAIL store_c3_ack: got dack,ifack=%b want 10", {d_ack1, if_ack1}); end
        d_req = 1'b0;
        d_we  = 1'b0;
        d_wstrb = 4'h0;
        d_wdata = 32'h0;
        step();
        // Load back: only the lower half of word 0x40 (0xA5001010) was replaced.
        d_req = 1'b1;
        step();
        n_cmp++;
        if ({mem_en1, mem_wstrb1} !== {1'b1, 4'h0}) begin
            n_bad++;
            $display("FAIL load_c1_strb: got en=%b strb=%b want 1 0000", mem_en1, mem_wstrb1);
        end
        step();
        step();
        n_cmp++;
        if ({d_ack1, d_rdata1} !== {1'b1, 32'hA500_BEEF}) begin
            n_bad++;
            $display("FAIL load_after_store: got ack=%b rdata=%h want 1 a500beef", d_ack1, d_rdata1);
        end
        d_req = 1'b0;
        step();
        // A store with no byte enables is still a full memory cycle and is acked.
        d_we    = 1'b1;
        d_wstrb = 4'b0000;
        d_wdata = 32'h1234_5678;
        d_req   = 1'b1;
        step();
        n_cmp++;
        if ({mem_en1, mem_wstrb1, mem_wdata1} !== {1'b1, 4'h0, 32'h1234_5678}) begin
            n_bad++;
            $display("FAIL zero_strb_c1: got en=%b strb=%b wdata=%h want 1 0000 12345678", mem_en1, mem_wstrb1, mem_wdata1);
        end
        step();
        step();
        n_cmp++;
        if (d_ack1 !== 1'b1) begin n_bad++; $display("FAIL zero_strb_ack: got %b want 1", d_ack1); end
        d_req = 1'b0;
        d_we  = 1'b0;
        step();
        step();
    endtask

    task automatic test_latency3();
        do_reset();
        if_addr = 32'h08;
        if_req  = 1'b1;
        for (int c = 0; c < 7; c++) begin
            n_cmp++;
            if ({mem_en3, busy3, if_ack3} !== {c == 1, c >= 1 && c <= 5, c == 5}) begin
                n_bad++;
                $display("FAIL lat3_cycle%0d: got en,busy,ack=%b want %b", c, {mem_en3, busy3, if_ack3},
                         {c == 1, c >= 1 && c <= 5, c == 5});
            end
            if (c == 5) begin
                n_cmp++;
                if (if_rdata3 !== 32'hA500_0202) begin
                    n_bad++;
                    $display("FAIL lat3_rdata: got %h want a5000202", if_rdata3);
                end
                if_req = 1'b0;
            end
            step();
        end
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_reset_mid();
        if_addr = 32'h10;
        if_req  = 1'b1;
        step();
        step();
        n_cmp++;
        if ({busy1, mem_en1} !== 2'b10) begin n_bad++; $display("FAIL mid_wait_state: got busy,en=%b want 10", {busy1, mem_en1}); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({if_ack1, d_ack1, mem_en1, busy1, if_rdata1, d_rdata1, mem_addr1, mem_wstrb1, mem_wdata1} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got %h want 0",
                     {if_ack1, d_ack1, mem_en1, busy1, if_rdata1, d_rdata1, mem_addr1, mem_wstrb1, mem_wdata1});
        end
        if_req = 1'b0;
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if ({if_ack1, d_ack1, busy1} !== 3'b000) begin
                n_bad++;
                $display("FAIL mid_no_ack_c%0d: got ifack,dack,busy=%b want 000", c, {if_ack1, d_ack1, busy1});
            end
            step();
        end
        if_addr = 32'h24;
        d_addr  = 32'h20;
        if_req  = 1'b1;
        d_req   = 1'b1;
        step();
        n_cmp++;
        if ({mem_en1, mem_addr1} !== {1'b1, 32'h20}) begin
            n_bad++;
            $display("FAIL mid_retie_cmd: got en=%b addr=%h want 1 20", mem_en1, mem_addr1);
        end
        step();
        step();
        n_cmp++;
        if ({d_ack1, if_ack1, d_rdata1} !== {1'b1, 1'b0, 32'hA500_0808}) begin
            n_bad++;
            $display("FAIL mid_retie_ack: got dack=%b ifack=%b rdata=%h want 1 0 a5000808", d_ack1, if_ack1, d_rdata1);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_addr_change();
        do_reset();
        if_addr = 32'h10;
        if_req  = 1'b1;
        step();
        if_addr = 32'h24;
        n_cmp++;
        if (mem_addr1 !== 32'h10) begin n_bad++; $display("FAIL addr_hold_c1: got %h want 10", mem_addr1); end
        step();
        n_cmp++;
        if (mem_addr1 !== 32'h10) begin n_bad++; $display("FAIL addr_hold_c2: got %h want 10", mem_addr1); end
        step();
        n_cmp++;
        if ({if_ack1, if_rdata1} !== {1'b1, 32'h0000_0013}) begin
            n_bad++;
            $display("FAIL addr_hold_rdata: got ack=%b rdata=%h want 1 00000013", if_ack1, if_rdata1);
        end
        if_req = 1'b0;
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_single_if_read();
        test_tie_alternate();
        test_store();
        test_latency3();
        test_reset_mid();
        test_addr_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
